// File: rtl/fir_mc_tdm.sv
// fir_mc_tdm: time-multiplexed multi-channel FIR filter with a single shared
// multiplier-accumulator, a run-time loadable coefficient bank and one delay
// line per channel. Each channel has a hold register and a pending flag; the
// FSM serves the lowest-index pending channel, one sample per TAPS+4 cycles.
// Build option: define FIR_SAT_EN to saturate the scaled result to the DW
// signed range; without it the low DW bits are kept (two's-complement wrap).
module fir_mc_tdm #(
    parameter int CH   = 2,
    parameter int DW   = 24,
    parameter int CW   = 18,
    parameter int TAPS = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        din_valid,
    input  logic signed [DW-1:0] din,
    output logic [CH-1:0]        dout_valid,
    output logic signed [DW-1:0] dout,
    input  logic                 coef_wr,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 busy,
    output logic                 overflow
);

    localparam int TW   = $clog2(TAPS);
    localparam int SW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW   = DW + CW;
    localparam int ACCW = DW + CW + TW;
    localparam logic [TW:0]   TAPS_T = (TW + 1)'(TAPS);
    localparam logic [AW:0]   TAPS_A = (AW + 1)'(TAPS);
    localparam logic [TW-1:0] LAST   = TW'(TAPS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT} state_t;

    logic signed [CW-1:0]   coef  [TAPS];
    logic signed [DW-1:0]   dline [CH][TAPS];
    logic signed [DW-1:0]   hold  [CH];
    logic [TW-1:0]          wr_ptr [CH];
    logic [CH-1:0]          pend;
    logic [CH-1:0]          take;
    logic [SW-1:0]          pick;
    logic                   any_pend;
    logic [SW-1:0]          sel;
    logic [TW-1:0]          tap;
    logic [TW:0]            rd_sum;
    logic [TW-1:0]          rd_idx;
    state_t                 state;
    logic signed [PW-1:0]   prod_p1;
    logic signed [ACCW-1:0] acc_p2;

    // Scale the accumulator from Q1.(CW-1) coefficient units back to samples
    // with an arithmetic (floor) shift, then fit the result into DW bits.
    function automatic logic signed [DW-1:0] scale(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] sh;
        sh = a >>> (CW - 1);
`ifdef FIR_SAT_EN
        if (sh > $signed({{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}}))
            return {1'b0, {(DW-1){1'b1}}};
        else if (sh < $signed({{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}}))
            return {1'b1, {(DW-1){1'b0}}};
        else
            return sh[DW-1:0];
`else
        return sh[DW-1:0];
`endif
    endfunction

    // Lowest-index pending channel and the flag it consumes when IDLE accepts it
    always_comb begin
        pick     = '0;
        any_pend = |pend;
        take     = '0;
        for (int c = CH - 1; c >= 0; c--) begin
            if (pend[c]) pick = SW'(c);
        end
        if (state == IDLE && any_pend) take[pick] = 1'b1;
    end

    // Circular read address: wr_ptr[sel] - tap modulo TAPS
    always_comb begin
        rd_sum = {1'b0, wr_ptr[sel]} + TAPS_T - {1'b0, tap};
        if (rd_sum >= TAPS_T) rd_sum = rd_sum - TAPS_T;
        rd_idx = rd_sum[TW-1:0];
    end

    assign busy = (state != IDLE) || (|pend);

    // Per-channel capture into hold registers; an unconsumed pending sample
    // that gets overwritten raises the sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            overflow <= 1'b0;
            for (int c = 0; c < CH; c++) hold[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (din_valid[c]) begin
                    hold[c] <= din;
                    pend[c] <= 1'b1;
                    if (pend[c] && !take[c]) overflow <= 1'b1;
                end else if (take[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

    // Coefficient bank: writes land only while idle and in range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) coef[k] <= '0;
        end else if (coef_wr && !busy && ({1'b0, coef_addr} < TAPS_A)) begin
            coef[coef_addr[TW-1:0]] <= coef_data;
        end
    end

    // Sequencer and shared MAC: load sample, TAPS products, drain, output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            tap        <= '0;
            prod_p1    <= '0;
            acc_p2     <= '0;
            dout       <= '0;
            dout_valid <= '0;
            for (int c = 0; c < CH; c++) begin
                wr_ptr[c] <= '0;
                for (int k = 0; k < TAPS; k++) dline[c][k] <= '0;
            end
        end else begin
            dout_valid <= '0;
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        sel   <= pick;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    dline[sel][wr_ptr[sel]] <= hold[sel];
                    acc_p2  <= '0;
                    prod_p1 <= '0;
                    tap     <= '0;
                    state   <= MAC;
                end
                MAC: begin
                    prod_p1 <= PW'(dline[sel][rd_idx]) * PW'(coef[tap]);
                    acc_p2  <= acc_p2 + ACCW'(prod_p1);
                    if (tap == LAST) state <= DRAIN;
                    else tap <= tap + 1'b1;
                end
                DRAIN: begin
                    acc_p2      <= acc_p2 + ACCW'(prod_p1);
                    wr_ptr[sel] <= (wr_ptr[sel] == LAST) ? '0 : wr_ptr[sel] + 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    dout       <= scale(acc_p2);
                    dout_valid <= CH'(1) << sel;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
